// File: rtl/sram_controller_pkg.sv
// Shared constants, state encoding and address-mapping helper for the memory-stage SRAM controller.
package sram_controller_pkg;

    localparam int LEN_REGISTER = 32;
    localparam int SRAM_DATA_W  = 16;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    // Byte address to 32-bit SRAM word index; the subtraction wraps and callers truncate.
    function automatic logic [LEN_REGISTER-1:0] sram_word(input logic [LEN_REGISTER-1:0] addr,
                                                          input logic [LEN_REGISTER-1:0] base);
        logic [LEN_REGISTER-1:0] diff;
        diff = addr - base;
        return {2'b00, diff[LEN_REGISTER-1:2]};
    endfunction

endpackage

// File: rtl/sram_controller_wait_counter.sv
// Wait-state counter: counts enabled cycles and flags the last one of a WAIT_CYCLES window.
module sram_controller_wait_counter #(
    parameter int WIDTH       = 4,
    parameter int WAIT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_last
);

    logic [WIDTH-1:0] r_count;

    assign o_last = (r_count == WIDTH'(WAIT_CYCLES - 1));

    // Count enabled cycles, wrapping to zero after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_clear) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_enable) begin
            if (o_last) begin
                r_count <= {WIDTH{1'b0}};
            end else begin
                r_count <= r_count + WIDTH'(1);
            end
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Memory-stage controller splitting 32-bit loads/stores into two 16-bit async SRAM accesses.
// Optional SRAM_CTRL_STATS_EN adds read/write/stall statistics counters.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic [LEN_REGISTER-1:0] i_address,
    input  logic [LEN_REGISTER-1:0] i_write_data,
    output logic [LEN_REGISTER-1:0] o_read_data,
    output logic                    o_ready,
    output logic [SRAM_ADDR_W-1:0]  o_sram_addr,
    output logic [SRAM_DATA_W-1:0]  o_sram_dq_out,
    input  logic [SRAM_DATA_W-1:0]  i_sram_dq_in,
    output logic                    o_sram_dq_oe,
    output logic                    o_sram_we_n
`ifdef SRAM_CTRL_STATS_EN
    ,
    output logic [31:0]             o_stat_reads,
    output logic [31:0]             o_stat_writes,
    output logic [31:0]             o_stat_stall_cycles
`endif
);

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      w_request;
    logic                      w_last;
    logic                      w_accept;
    logic                      w_busy;
    logic [SRAM_ADDR_W-2:0]    w_word;
    logic [SRAM_ADDR_W-2:0]    r_word;
    logic [LEN_REGISTER-1:0]   r_wdata;
    logic                      r_is_write;
    logic [LEN_REGISTER-1:0]   r_read_data;

    assign w_request   = i_mem_read | i_mem_write;
    assign w_accept    = (r_state == IDLE) && w_request;
    assign w_busy      = (r_state == LOW) || (r_state == HIGH);
    assign w_word      = (SRAM_ADDR_W - 1)'(sram_word(i_address, 32'(BASE_ADDR)));
    assign o_read_data = r_read_data;

    sram_controller_wait_counter #(
        .WIDTH       (CNT_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (~w_busy),
        .i_enable (w_busy),
        .o_last   (w_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and SRAM strobes; DONE always returns to IDLE so a stale request cannot re-fire.
    always_comb begin
        w_next_state  = r_state;
        o_ready       = 1'b1;
        o_sram_addr   = {SRAM_ADDR_W{1'b0}};
        o_sram_dq_out = {SRAM_DATA_W{1'b0}};
        o_sram_dq_oe  = 1'b0;
        o_sram_we_n   = 1'b1;
        case (r_state)
            IDLE: begin
                o_ready = ~w_request;
                if (w_request) begin
                    w_next_state = LOW;
                end else begin
                    w_next_state = IDLE;
                end
            end
            LOW, HIGH: begin
                o_ready     = 1'b0;
                o_sram_addr = {r_word, (r_state == HIGH)};
                if (r_is_write) begin
                    o_sram_dq_oe  = 1'b1;
                    o_sram_we_n   = 1'b0;
                    o_sram_dq_out = (r_state == HIGH) ? r_wdata[31:16] : r_wdata[15:0];
                end else begin
                    o_sram_dq_oe  = 1'b0;
                end
                if (w_last) begin
                    w_next_state = (r_state == HIGH) ? DONE : HIGH;
                end else begin
                    w_next_state = r_state;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Capture the request operands when an access is accepted; a simultaneous read+write is a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word     <= {(SRAM_ADDR_W-1){1'b0}};
            r_wdata    <= {LEN_REGISTER{1'b0}};
            r_is_write <= 1'b0;
        end else if (w_accept) begin
            r_word     <= w_word;
            r_wdata    <= i_write_data;
            r_is_write <= i_mem_write;
        end else begin
            r_word     <= r_word;
            r_wdata    <= r_wdata;
            r_is_write <= r_is_write;
        end
    end

    // Load result: sample each half on the final wait cycle of its access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_data <= {LEN_REGISTER{1'b0}};
        end else if (!r_is_write && w_last && (r_state == LOW)) begin
            r_read_data[15:0] <= i_sram_dq_in;
        end else if (!r_is_write && w_last && (r_state == HIGH)) begin
            r_read_data[31:16] <= i_sram_dq_in;
        end else begin
            r_read_data <= r_read_data;
        end
    end

`ifdef SRAM_CTRL_STATS_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;
    logic [31:0] r_stat_stall_cycles;

    assign o_stat_reads        = r_stat_reads;
    assign o_stat_writes       = r_stat_writes;
    assign o_stat_stall_cycles = r_stat_stall_cycles;

    // Access counters bump on acceptance; stalls count the LOW/HIGH cycles of each access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_reads        <= 32'd0;
            r_stat_writes       <= 32'd0;
            r_stat_stall_cycles <= 32'd0;
        end else begin
            r_stat_reads        <= r_stat_reads + 32'((w_accept && !i_mem_write) ? 1 : 0);
            r_stat_writes       <= r_stat_writes + 32'((w_accept && i_mem_write) ? 1 : 0);
            r_stat_stall_cycles <= r_stat_stall_cycles + 32'(w_busy ? 1 : 0);
        end
    end
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench for sram_controller with a small behavioural SRAM model.
module tb_sram_controller;

    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
`ifdef SRAM_CTRL_STATS_EN
    logic [31:0] stat_reads;
    logic [31:0] stat_writes;
    logic [31:0] stat_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] sram_mem [0:15];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr[3:0]] <= sram_dq_out;
    end
    assign sram_dq_in = sram_mem[sram_addr[3:0]];

    sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(1024), .SRAM_ADDR_W(18)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_mem_read    (mem_read),
        .i_mem_write   (mem_write),
        .i_address     (address),
        .i_write_data  (write_data),
        .o_read_data   (read_data),
        .o_ready       (ready),
        .o_sram_addr   (sram_addr),
        .o_sram_dq_out (sram_dq_out),
        .i_sram_dq_in  (sram_dq_in),
        .o_sram_dq_oe  (sram_dq_oe),
        .o_sram_we_n   (sram_we_n)
`ifdef SRAM_CTRL_STATS_EN
        ,
        .o_stat_reads        (stat_reads),
        .o_stat_writes       (stat_writes),
        .o_stat_stall_cycles (stat_stall_cycles)
`endif
    );

    task automatic test_reset();
        #2;
        checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'd0
            || sram_dq_out !== 16'd0 || read_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_values ready=%b we_n=%b oe=%b addr=%0d dq=%h rd=%h want 1 1 0 0 0000 00000000",
                     ready, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out, read_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_idle ready=%b we_n=%b want 1 1", ready, sram_we_n);
        end
    endtask

    task automatic test_write();
        logic [17:0] exp_addr;
        logic [15:0] exp_dq;
        mem_write = 1'b1; address = 32'd1032; write_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL wr_issue_ready got %b want 0", ready);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 2*W; c++) begin
            exp_addr = (c < W) ? 18'd4 : 18'd5;
            exp_dq   = (c < W) ? 16'hBEEF : 16'hDEAD;
            checks++;
            if (ready !== 1'b0 || sram_addr !== exp_addr || sram_dq_out !== exp_dq
                || sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1) begin
                errors++;
                $display("FAIL wr_cycle%0d ready=%b addr=%0d dq=%h we_n=%b oe=%b want 0 %0d %h 0 1",
                         c, ready, sram_addr, sram_dq_out, sram_we_n, sram_dq_oe, exp_addr, exp_dq);
            end
            if (c == 1) begin
                address = 32'd2000; write_data = 32'h00000000;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL wr_done ready=%b we_n=%b oe=%b want 1 1 0", ready, sram_we_n, sram_dq_oe);
        end
        mem_write = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_addr !== 18'd0) begin
            errors++;
            $display("FAIL wr_after_idle ready=%b we_n=%b addr=%0d want 1 1 0", ready, sram_we_n, sram_addr);
        end
        checks++;
        if (sram_mem[4] !== 16'hBEEF || sram_mem[5] !== 16'hDEAD || read_data !== 32'd0) begin
            errors++;
            $display("FAIL wr_contents mem4=%h mem5=%h rd=%h want beef dead 00000000",
                     sram_mem[4], sram_mem[5], read_data);
        end
    endtask

    task automatic test_read();
        logic [17:0] exp_addr;
        mem_read = 1'b1; address = 32'd1032;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL rd_issue_ready got %b want 0", ready);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 2*W; c++) begin
            exp_addr = (c < W) ? 18'd4 : 18'd5;
            checks++;
            if (ready !== 1'b0 || sram_addr !== exp_addr || sram_dq_oe !== 1'b0 || sram_we_n !== 1'b1) begin
                errors++;
                $display("FAIL rd_cycle%0d ready=%b addr=%0d oe=%b we_n=%b want 0 %0d 0 1",
                         c, ready, sram_addr, sram_dq_oe, sram_we_n, exp_addr);
            end
            if (c == W) begin
                checks++;
                if (read_data !== 32'h0000BEEF) begin
                    errors++; $display("FAIL rd_low_half got %h want 0000beef", read_data);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ready !== 1'b1 || read_data !== 32'hDEADBEEF || sram_dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL rd_done ready=%b rd=%h oe=%b want 1 deadbeef 0", ready, read_data, sram_dq_oe);
        end
        mem_read = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (read_data !== 32'hDEADBEEF || ready !== 1'b1) begin
            errors++; $display("FAIL rd_hold rd=%h ready=%b want deadbeef 1", read_data, ready);
        end
    endtask

    task automatic test_both();
        logic [17:0] exp_addr;
        logic [15:0] exp_dq;
        mem_read = 1'b1; mem_write = 1'b1; address = 32'd1024; write_data = 32'h12345678;
        @(posedge clk); #1;
        for (int c = 0; c < 2*W; c++) begin
            exp_addr = (c < W) ? 18'd0 : 18'd1;
            exp_dq   = (c < W) ? 16'h5678 : 16'h1234;
            checks++;
            if (sram_addr !== exp_addr || sram_dq_out !== exp_dq || sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1) begin
                errors++;
                $display("FAIL both_cycle%0d addr=%0d dq=%h we_n=%b oe=%b want %0d %h 0 1",
                         c, sram_addr, sram_dq_out, sram_we_n, sram_dq_oe, exp_addr, exp_dq);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ready !== 1'b1 || read_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL both_done ready=%b rd=%h want 1 deadbeef", ready, read_data);
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (sram_mem[0] !== 16'h5678 || sram_mem[1] !== 16'h1234) begin
            errors++; $display("FAIL both_contents mem0=%h mem1=%h want 5678 1234", sram_mem[0], sram_mem[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp_addr;
        int          we_low;
        mem_read = 1'b1; address = 32'd1024;
        @(posedge clk); #1;
        for (int c = 0; c < 2*W; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (ready !== 1'b1 || read_data !== 32'h12345678) begin
            errors++; $display("FAIL b2b_load_done ready=%b rd=%h want 1 12345678", ready, read_data);
        end
        mem_read = 1'b0; mem_write = 1'b1; address = 32'd1040; write_data = 32'hA5A55A5A;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL b2b_done_ignores_req ready=%b want 1", ready);
        end
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b0 || sram_we_n !== 1'b1 || sram_addr !== 18'd0) begin
            errors++;
            $display("FAIL b2b_idle_gap ready=%b we_n=%b addr=%0d want 0 1 0", ready, sram_we_n, sram_addr);
        end
        @(posedge clk); #1;
        we_low = 0;
        for (int c = 0; c < 2*W; c++) begin
            exp_addr = (c < W) ? 18'd8 : 18'd9;
            if (sram_we_n === 1'b0) we_low++;
            checks++;
            if (sram_addr !== exp_addr || ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_store_cycle%0d addr=%0d ready=%b want %0d 0", c, sram_addr, ready, exp_addr);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (we_low !== 2*W || ready !== 1'b1) begin
            errors++; $display("FAIL b2b_store_len we_low=%0d ready=%b want %0d 1", we_low, ready, 2*W);
        end
        mem_write = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (sram_we_n !== 1'b1 || ready !== 1'b1) begin
                errors++; $display("FAIL b2b_no_dup%0d we_n=%b ready=%b want 1 1", c, sram_we_n, ready);
            end
        end
        checks++;
        if (sram_mem[8] !== 16'h5A5A || sram_mem[9] !== 16'hA5A5 || read_data !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b_contents mem8=%h mem9=%h rd=%h want 5a5a a5a5 12345678",
                     sram_mem[8], sram_mem[9], read_data);
        end
    endtask

    task automatic test_reset_mid();
        mem_write = 1'b1; address = 32'd1024; write_data = 32'h11112222;
        @(posedge clk); #1;
        checks++;
        if (sram_we_n !== 1'b0) begin
            errors++; $display("FAIL rst_mid_pre we_n=%b want 0", sram_we_n);
        end
        #2;
        rst_n = 1'b0; mem_write = 1'b0;
        #1;
        checks++;
        if (sram_we_n !== 1'b1 || ready !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'd0
            || read_data !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid we_n=%b ready=%b oe=%b addr=%0d rd=%h want 1 1 0 0 00000000",
                     sram_we_n, ready, sram_dq_oe, sram_addr, read_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sram_we_n !== 1'b1 || ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_after we_n=%b ready=%b want 1 1", sram_we_n, ready);
        end
    endtask

`ifdef SRAM_CTRL_STATS_EN
    task automatic test_stats();
        mem_read = 1'b1; address = 32'd1032;
        repeat (2*W + 1) @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b1; address = 32'd1044; write_data = 32'h0BADF00D;
        @(posedge clk); #1;
        repeat (2*W + 1) @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (stat_reads !== 32'd1 || stat_writes !== 32'd1 || stat_stall_cycles !== 32'(4*W)) begin
            errors++;
            $display("FAIL stats reads=%0d writes=%0d stall=%0d want 1 1 %0d",
                     stat_reads, stat_writes, stat_stall_cycles, 4*W);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_both();
        test_back_to_back();
        test_reset_mid();
`ifdef SRAM_CTRL_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
